// File: rtl/huffman_ctrl_pkg.sv
// Shared constants and state encoding for the Huffman bitstream sequencer.
package huffman_ctrl_pkg;

  localparam int unsigned COEFS_PER_BLOCK = 64;
  localparam int unsigned BYTE_W          = 8;
  localparam int unsigned BITS_W          = 4;
  localparam int unsigned COEF_W          = 7;
  localparam int unsigned SUM_W           = 8;
  localparam int unsigned RUN_W           = 5;
  localparam int unsigned BLK_W           = 16;
  localparam int unsigned BLK_CMP_W       = BLK_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEC_RST,
    ST_FEED,
    ST_DONE,
    ST_ERR
  } ctrl_state_e;

endpackage

// File: rtl/huffman_stream_ctrl_byte_serializer.sv
// Byte-to-bit serializer: loads accepted bytes and shifts them out MSB-first, one bit per cycle.
module byte_serializer
  import huffman_ctrl_pkg::*;
(
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              enable,
  input  logic              flush,
  input  logic [BYTE_W-1:0] byte_in,
  input  logic              byte_valid_in,
  output logic              byte_ready_c,
  output logic              ser_bit,
  output logic              ser_valid
);

  logic [BYTE_W-1:0] shreg;
  logic [BITS_W-1:0] bits_left;

  // Ready while the last bit is leaving so consecutive bytes stream without a gap.
  assign byte_ready_c = enable && (bits_left <= BITS_W'(1));

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      shreg     <= '0;
      bits_left <= '0;
      ser_bit   <= 1'b0;
      ser_valid <= 1'b0;
    end else begin
      ser_valid <= 1'b0;
      if (flush) begin
        bits_left <= '0;
      end else begin
        if (bits_left != '0) begin
          ser_bit   <= shreg[BYTE_W-1];
          ser_valid <= 1'b1;
          shreg     <= {shreg[BYTE_W-2:0], 1'b0};
          bits_left <= bits_left - BITS_W'(1);
        end
        if (byte_ready_c && byte_valid_in) begin
          shreg     <= byte_in;
          bits_left <= BITS_W'(BYTE_W);
        end
      end
    end
  end

endmodule

// File: rtl/huffman_stream_ctrl.sv
// Frame sequencer for huffman_decoder: feeds the bitstream serially, counts coefficients and
// blocks, resets the decoder between frames and flags overflow or stalled streams.
module huffman_stream_ctrl
  import huffman_ctrl_pkg::*;
#(
  parameter int unsigned BLOCKS_PER_FRAME = 300,
  parameter int unsigned STALL_BITS       = 64
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              start_in,
  input  logic [BYTE_W-1:0] byte_in,
  input  logic              byte_valid_in,
  output logic              byte_ready_out,
  output logic              dec_serial_out,
  output logic              dec_valid_out,
  output logic              dec_rst_out,
  input  logic              dec_valid_in,
  input  logic              dec_dc_in,
  input  logic [RUN_W-1:0]  dec_run_in,
  output logic              block_done_out,
  output logic              frame_done_out,
  output logic [BLK_W-1:0]  blocks_done_out,
  output logic              busy_out,
  output logic              error_out
);

  localparam int unsigned STALL_W = $clog2(STALL_BITS + 1);

  ctrl_state_e          state;
  ctrl_state_e          state_nxt;
  logic [COEF_W-1:0]    coef_cnt;
  logic [STALL_W-1:0]   stall_cnt;
  logic [SUM_W-1:0]     coef_sum;
  logic [BLK_CMP_W-1:0] blocks_inc;
  logic                 feed;
  logic                 sym_valid;
  logic                 ac_sym;
  logic                 overflow;
  logic                 blk_end;
  logic                 frame_end;
  logic                 stall;
  logic                 flush;

  assign feed       = (state == ST_FEED);
  assign sym_valid  = feed && dec_valid_in;
  assign ac_sym     = sym_valid && !dec_dc_in;
  assign coef_sum   = SUM_W'(coef_cnt) + SUM_W'(dec_run_in) + SUM_W'(1);
  assign overflow   = ac_sym && ((coef_cnt == '0) || (coef_sum > SUM_W'(COEFS_PER_BLOCK)));
  assign blk_end    = ac_sym && (coef_cnt != '0) && (coef_sum == SUM_W'(COEFS_PER_BLOCK));
  assign blocks_inc = BLK_CMP_W'(blocks_done_out) + BLK_CMP_W'(1);
  assign frame_end  = blk_end && (blocks_inc == BLK_CMP_W'(BLOCKS_PER_FRAME));
  assign stall      = feed && dec_valid_out && !dec_valid_in &&
                      (stall_cnt == STALL_W'(STALL_BITS - 1));
  // Drop unsent bits on the edge that leaves FEED so nothing reaches a decoder being reset.
  assign flush      = (state_nxt == ST_DONE) || (state_nxt == ST_ERR);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (start_in) state_nxt = ST_DEC_RST;
      ST_DEC_RST: state_nxt = ST_FEED;
      ST_FEED: begin
        if (overflow || stall) state_nxt = ST_ERR;
        else if (frame_end)    state_nxt = ST_DONE;
      end
      ST_DONE:    state_nxt = ST_IDLE;
      ST_ERR:     if (start_in) state_nxt = ST_DEC_RST;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Status outputs follow the next state so they line up with the state they describe.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      dec_rst_out    <= 1'b1;
      busy_out       <= 1'b0;
      error_out      <= 1'b0;
      block_done_out <= 1'b0;
      frame_done_out <= 1'b0;
    end else begin
      dec_rst_out    <= state_nxt inside {ST_DEC_RST, ST_DONE, ST_ERR};
      busy_out       <= !(state_nxt inside {ST_IDLE, ST_ERR});
      block_done_out <= blk_end;
      frame_done_out <= frame_end;
      if (state_nxt == ST_DEC_RST)  error_out <= 1'b0;
      else if (state_nxt == ST_ERR) error_out <= 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      coef_cnt        <= '0;
      stall_cnt       <= '0;
      blocks_done_out <= '0;
    end else if (state_nxt == ST_DEC_RST) begin
      coef_cnt        <= '0;
      stall_cnt       <= '0;
      blocks_done_out <= '0;
    end else if (feed) begin
      if (dec_valid_in)       stall_cnt <= '0;
      else if (dec_valid_out) stall_cnt <= stall_cnt + STALL_W'(1);
      if (sym_valid) begin
        if (dec_dc_in) begin
          coef_cnt <= COEF_W'(1);
        end else if (blk_end) begin
          coef_cnt        <= '0;
          blocks_done_out <= BLK_W'(blocks_inc);
        end else if (!overflow) begin
          coef_cnt <= COEF_W'(coef_sum);
        end
      end
    end
  end

  byte_serializer u_ser (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .enable        (feed),
    .flush         (flush),
    .byte_in       (byte_in),
    .byte_valid_in (byte_valid_in),
    .byte_ready_c  (byte_ready_out),
    .ser_bit       (dec_serial_out),
    .ser_valid     (dec_valid_out)
  );

endmodule

// File: tb/tb_huffman_stream_ctrl.sv
// Scoreboard bench for huffman_stream_ctrl: random bytes and decoder symbols against a frame-level model.
`timescale 1ns/1ps
module tb_huffman_stream_ctrl;

  localparam int unsigned BPF   = 3;
  localparam int unsigned STALL = 64;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        start_in = 1'b0;
  logic [7:0]  byte_in = '0;
  logic        byte_valid_in = 1'b0;
  logic        byte_ready_out;
  logic        dec_serial_out;
  logic        dec_valid_out;
  logic        dec_rst_out;
  logic        dec_valid_in = 1'b0;
  logic        dec_dc_in = 1'b0;
  logic [4:0]  dec_run_in = '0;
  logic        block_done_out;
  logic        frame_done_out;
  logic [15:0] blocks_done_out;
  logic        busy_out;
  logic        error_out;

  huffman_stream_ctrl #(.BLOCKS_PER_FRAME(BPF), .STALL_BITS(STALL)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .start_in(start_in),
    .byte_in(byte_in), .byte_valid_in(byte_valid_in), .byte_ready_out(byte_ready_out),
    .dec_serial_out(dec_serial_out), .dec_valid_out(dec_valid_out), .dec_rst_out(dec_rst_out),
    .dec_valid_in(dec_valid_in), .dec_dc_in(dec_dc_in), .dec_run_in(dec_run_in),
    .block_done_out(block_done_out), .frame_done_out(frame_done_out),
    .blocks_done_out(blocks_done_out), .busy_out(busy_out), .error_out(error_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct { bit blk; bit frm; bit err; int blocks; } ev_t;
  ev_t ev_q[$];
  bit  exp_bits[$];

  int n_tests = 0, n_fail = 0;
  int cyc = 0, bits_total = 0, bits_at_err = -1, first_v = -1, last_v = -1;
  bit err_q = 1'b0;
  int m_coef = 0, m_blocks = 0;
  bit m_err = 1'b0, m_active = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expected bits and frame events whenever the DUT presents them.
  always @(negedge clk_in) begin
    cyc++;
    if (rst_n_in) begin
      if (dec_valid_out) begin
        bits_total++;
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
        check("bit_expected", 64'(exp_bits.size() > 0), 1);
        if (exp_bits.size() > 0) begin
          bit b;
          b = exp_bits.pop_front();
          check("serial_bit", dec_serial_out, b);
        end
      end
      if (block_done_out || frame_done_out || (error_out && !err_q)) begin
        if (error_out && !err_q) bits_at_err = bits_total;
        check("event_expected", 64'(ev_q.size() > 0), 1);
        if (ev_q.size() > 0) begin
          ev_t e;
          e = ev_q.pop_front();
          check("block_done", block_done_out, e.blk);
          check("frame_done", frame_done_out, e.frm);
          check("error_rise", error_out && !err_q, e.err);
          check("blocks_done", blocks_done_out, 64'(e.blocks));
          check("dec_rst_on_event", dec_rst_out, e.frm || e.err);
          check("busy_on_event", busy_out, !e.err);
        end
      end
    end
    err_q = error_out;
  end

  // Reference model: coefficient positions per block, blocks per frame.
  task automatic send_sym(input bit dc, input int run);
    ev_t e;
    dec_valid_in = 1'b1; dec_dc_in = dc; dec_run_in = 5'(run);
    if (m_active && !m_err) begin
      if (dc) m_coef = 1;
      else if (m_coef == 0 || m_coef + run + 1 > 64) begin
        m_err = 1'b1;
        e = '{blk: 1'b0, frm: 1'b0, err: 1'b1, blocks: m_blocks};
        ev_q.push_back(e);
      end else begin
        m_coef += run + 1;
        if (m_coef == 64) begin
          m_coef = 0;
          m_blocks++;
          e = '{blk: 1'b1, frm: (m_blocks == int'(BPF)), err: 1'b0, blocks: m_blocks};
          ev_q.push_back(e);
          if (m_blocks == int'(BPF)) m_active = 1'b0;
        end
      end
    end
    @(negedge clk_in);
    dec_valid_in = 1'b0; dec_dc_in = 1'b0; dec_run_in = '0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int g = 0;
    byte_in = b; byte_valid_in = 1'b1;
    while (!byte_ready_out && g < 500) begin
      @(negedge clk_in);
      g++;
    end
    check("byte_accepted", byte_ready_out, 1);
    if (byte_ready_out) begin
      for (int i = 7; i >= 0; i--) exp_bits.push_back(b[i]);
      @(negedge clk_in);
    end
    byte_valid_in = 1'b0;
  endtask

  task automatic wait_drain();
    int g = 0;
    while (exp_bits.size() != 0 && g < 1000) begin
      @(negedge clk_in);
      g++;
    end
    check("bits_drained", 64'(exp_bits.size()), 0);
    repeat (2) @(negedge clk_in);
  endtask

  task automatic start_frame();
    start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    check("dec_rst_at_start", dec_rst_out, 1);
    check("busy_at_start", busy_out, 1);
    check("error_cleared", error_out, 0);
    check("blocks_cleared", blocks_done_out, 0);
    m_coef = 0; m_blocks = 0; m_err = 1'b0; m_active = 1'b1;
    @(negedge clk_in);
    check("dec_rst_released", dec_rst_out, 0);
  endtask

  // DC, random AC runs, then EOB closing the block at 64 (EOB run kept within 5 bits).
  task automatic send_block();
    int rem = 63;
    int r;
    send_sym(1'b1, 0);
    while (rem > 32 || (rem > 1 && $urandom_range(0, 2) != 0)) begin
      r = int'($urandom_range(0, (rem - 2 < 15) ? rem - 2 : 15));
      send_sym(1'b0, r);
      rem -= r + 1;
      repeat ($urandom_range(0, 2)) @(negedge clk_in);
    end
    send_sym(1'b0, rem - 1);
  endtask

  task automatic frame_of_blocks();
    for (int k = 0; k < int'(BPF); k++) send_block();
    repeat (3) @(negedge clk_in);
    check("frame_busy_low", busy_out, 0);
    check("frame_blocks", blocks_done_out, 64'(BPF));
    check("frame_no_error", error_out, 0);
    check("frame_dec_rst_low", dec_rst_out, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit bytes_done;
    int b0;

    #23;
    check("rst_dec_rst", dec_rst_out, 1);
    check("rst_busy", busy_out, 0);
    check("rst_error", error_out, 0);
    check("rst_valid", dec_valid_out, 0);
    check("rst_ready", byte_ready_out, 0);
    check("rst_blocks", blocks_done_out, 0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(negedge clk_in);
    check("idle_dec_rst", dec_rst_out, 0);
    check("idle_ready", byte_ready_out, 0);

    // Gapless 0xA5 stream
    start_frame();
    first_v = -1;
    b0 = bits_total;
    for (int i = 0; i < 4; i++) send_byte(8'hA5);
    wait_drain();
    check("a5_bits", 64'(bits_total - b0), 32);
    check("a5_span", 64'(last_v - first_v + 1), 32);
    send_sym(1'b1, 0);

    // Starvation does not stall; start during FEED ignored
    repeat (1000) @(negedge clk_in);
    check("starve_no_error", error_out, 0);
    check("starve_busy", busy_out, 1);
    start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    check("start_ignored_rst", dec_rst_out, 0);
    check("start_ignored_busy", busy_out, 1);

    // Random bytes with periodic DC symbols keeping the stall counter clear
    bytes_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          send_byte(8'($urandom));
          repeat ($urandom_range(0, 3)) @(negedge clk_in);
        end
        bytes_done = 1'b1;
      end
      begin
        while (!bytes_done) begin
          repeat ($urandom_range(2, 12)) @(negedge clk_in);
          send_sym(1'b1, 0);
        end
      end
    join
    wait_drain();
    frame_of_blocks();

    // Coefficient overflow: 1 + 16*4 = 65
    start_frame();
    send_sym(1'b1, 0);
    send_sym(1'b0, 15); send_sym(1'b0, 15); send_sym(1'b0, 15); send_sym(1'b0, 15);
    send_sym(1'b0, 2);
    repeat (2) @(negedge clk_in);
    check("ovf_error", error_out, 1);
    check("ovf_busy", busy_out, 0);
    check("ovf_blocks", blocks_done_out, 0);

    // AC symbol with no DC first
    start_frame();
    send_sym(1'b0, 3);
    repeat (2) @(negedge clk_in);
    check("ac_first_error", error_out, 1);

    // Stall after exactly STALL bits without decoder output
    start_frame();
    ev_q.push_back('{blk: 1'b0, frm: 1'b0, err: 1'b1, blocks: 0});
    m_err = 1'b1;
    b0 = bits_total;
    bits_at_err = -1;
    for (int i = 0; i < int'(STALL) / 8; i++) send_byte(8'($urandom));
    begin
      int g = 0;
      while (!error_out && g < 200) begin
        @(negedge clk_in);
        g++;
      end
    end
    @(negedge clk_in);
    check("stall_error", error_out, 1);
    check("stall_bits", 64'(bits_at_err - b0), 64'(STALL));
    check("stall_bits_left", 64'(exp_bits.size()), 0);

    // Asynchronous reset mid-byte, then a clean frame
    start_frame();
    send_byte(8'h3C);
    repeat (3) @(negedge clk_in);
    #2 rst_n_in = 1'b0;
    #1;
    check("arst_valid", dec_valid_out, 0);
    check("arst_busy", busy_out, 0);
    check("arst_dec_rst", dec_rst_out, 1);
    check("arst_blocks", blocks_done_out, 0);
    check("arst_ready", byte_ready_out, 0);
    exp_bits.delete();
    m_active = 1'b0;
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(negedge clk_in);
    check("arst_release_dec_rst", dec_rst_out, 0);
    start_frame();
    send_byte(8'($urandom));
    send_byte(8'($urandom));
    wait_drain();
    frame_of_blocks();

    repeat (5) @(negedge clk_in);
    check("events_consumed", 64'(ev_q.size()), 0);
    check("bits_consumed", 64'(exp_bits.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
